// File: rtl/debug_arb_pkg.sv
// ============================================================================
// debug_arb_pkg : shared types, constants and round-robin helper for the
//                 debug_port_arbiter codebase slice.
// Revision      : 1.0  initial release
// ============================================================================
`default_nettype none

package debug_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_TAG   = 2'd2,
        ST_GRANT = 2'd3
    } arb_state_t;

    localparam logic [7:0] TAG_MAGIC = 8'hA5;

    // First requesting index strictly after ptr, cyclic over n sources; ptr
    // itself is reached last, so a sole requester wins again.
    function automatic logic [2:0] rr_next(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [2:0] idx;
        logic       found;
        rr_next = ptr;
        found   = 1'b0;
        for (int k = 1; k <= n; k++) begin
            idx = 3'((int'(ptr) + k) % n);
            if (!found && req[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/btn_press_classifier.sv
// ============================================================================
// btn_press_classifier : synchronises and debounces the active-low PB[2]
//                        button and emits one-cycle short/long press pulses.
// Revision             : 1.0  initial release
// ============================================================================
`default_nettype none

module btn_press_classifier #(
    parameter int DB_CYCLES   = 24,
    parameter int LONG_CYCLES = 1200
) (
    input  logic clk0012p0,
    input  logic user_reset_button,
    input  logic btn_n,
    output logic short_press,
    output logic long_press
);

    localparam int DB_W   = $clog2(DB_CYCLES + 1);
    localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    // Synchroniser carries the inverted button so "cleared" means released.
    logic [1:0]        sync;
    logic              db_level;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;

    always_ff @(posedge clk0012p0 or posedge user_reset_button) begin
        if (user_reset_button) begin
            sync        <= 2'b00;
            db_level    <= 1'b0;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            short_press <= 1'b0;
            long_press  <= 1'b0;
        end else begin
            sync        <= {sync[0], ~btn_n};
            short_press <= 1'b0;
            long_press  <= 1'b0;

            if (db_level && hold_cnt != HOLD_MAX) begin
                hold_cnt <= hold_cnt + 1'b1;
                if (hold_cnt == HOLD_LAST)
                    long_press <= 1'b1;
            end

            if (sync[1] != db_level) begin
                if (db_cnt == DB_LAST) begin
                    db_level <= sync[1];
                    db_cnt   <= '0;
                    if (!sync[1]) begin
                        // A release that coincides with reaching the long
                        // threshold is reported as long only.
                        if (hold_cnt < HOLD_LAST)
                            short_press <= 1'b1;
                        hold_cnt <= '0;
                    end
                end else begin
                    db_cnt <= db_cnt + 1'b1;
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/debug_port_arbiter.sv
// ============================================================================
// debug_port_arbiter : time-shares the DEBUG/PMOD port between N_SRC sources,
//                      round-robin (AUTO) or button-selected (MANUAL).
//                      Optional ID tag frame: define DEBUG_ARB_TAG_EN.
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module debug_port_arbiter
    import debug_arb_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int W           = 16,
    parameter int DWELL       = 600,
    parameter int DB_CYCLES   = 24,
    parameter int LONG_CYCLES = 1200,
    parameter int TAG_CYCLES  = 120
) (
    input  logic                     clk0012p0,
    input  logic                     user_reset_button,
    input  logic [N_SRC-1:0]         req,
    input  logic [N_SRC*W-1:0]       src_data,
    input  logic                     btn_n,
    output logic [W-1:0]             debug_out,
    output logic [N_SRC-1:0]         grant,
    output logic                     mode_manual,
    output logic [$clog2(N_SRC)-1:0] active_id
);

    localparam int ID_W    = $clog2(N_SRC);
    localparam int CNT_MAX = (DWELL > TAG_CYCLES) ? DWELL : TAG_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
`ifdef DEBUG_ARB_TAG_EN
    localparam logic [CNT_W-1:0] TAG_LAST   = CNT_W'(TAG_CYCLES - 1);
`endif

    logic [N_SRC-1:0] req_meta;
    logic [N_SRC-1:0] req_sync;
    arb_state_t       state;
    logic [ID_W-1:0]  rr_ptr;
    logic [CNT_W-1:0] dwell_cnt;
    logic             short_press;
    logic             long_press;
    logic [ID_W-1:0]  winner;
    logic [W-1:0]     src_word;

    btn_press_classifier #(
        .DB_CYCLES   (DB_CYCLES),
        .LONG_CYCLES (LONG_CYCLES)
    ) u_btn (
        .clk0012p0         (clk0012p0),
        .user_reset_button (user_reset_button),
        .btn_n             (btn_n),
        .short_press       (short_press),
        .long_press        (long_press)
    );

    assign winner   = ID_W'(rr_next(8'(req_sync), 3'(rr_ptr), N_SRC));
    assign src_word = src_data[active_id*W +: W];

    function automatic logic [N_SRC-1:0] onehot(input logic [ID_W-1:0] id);
        return N_SRC'(1) << id;
    endfunction

`ifdef DEBUG_ARB_TAG_EN
    function automatic logic [W-1:0] tag_word(input logic [ID_W-1:0] id);
        return W'({TAG_MAGIC, 4'h0, 1'b0, 3'(id)});
    endfunction
`endif

    // dwell_cnt doubles as the tag-frame counter; the two phases never overlap.
    always_ff @(posedge clk0012p0 or posedge user_reset_button) begin
        if (user_reset_button) begin
            req_meta    <= '0;
            req_sync    <= '0;
            state       <= ST_IDLE;
            rr_ptr      <= ID_W'(N_SRC - 1);
            active_id   <= '0;
            grant       <= '0;
            debug_out   <= '0;
            dwell_cnt   <= '0;
            mode_manual <= 1'b0;
        end else begin
            req_meta <= req;
            req_sync <= req_meta;

            if (short_press) begin
                dwell_cnt <= '0;
                if (!mode_manual) begin
                    mode_manual <= 1'b1;
                    grant       <= onehot(active_id);
                    state       <= ST_GRANT;
                end else begin
                    active_id <= active_id + 1'b1;
                    grant     <= onehot(active_id + 1'b1);
`ifdef DEBUG_ARB_TAG_EN
                    state     <= ST_TAG;
                    debug_out <= tag_word(active_id + 1'b1);
`else
                    state     <= ST_GRANT;
`endif
                end
            end else if (long_press) begin
                mode_manual <= 1'b0;
                grant       <= '0;
                state       <= ST_ARB;
            end else if (mode_manual) begin
                grant <= onehot(active_id);
`ifdef DEBUG_ARB_TAG_EN
                if (state == ST_TAG) begin
                    if (dwell_cnt == TAG_LAST) begin
                        state     <= ST_GRANT;
                        debug_out <= src_word;
                        dwell_cnt <= '0;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end else begin
                    debug_out <= src_word;
                end
`else
                debug_out <= src_word;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        grant <= '0;
                        if (|req_sync)
                            state <= ST_ARB;
                    end
                    ST_ARB: begin
                        if (|req_sync) begin
                            rr_ptr    <= winner;
                            active_id <= winner;
                            grant     <= onehot(winner);
                            dwell_cnt <= '0;
`ifdef DEBUG_ARB_TAG_EN
                            state     <= ST_TAG;
                            debug_out <= tag_word(winner);
`else
                            state     <= ST_GRANT;
`endif
                        end else begin
                            grant <= '0;
                            state <= ST_IDLE;
                        end
                    end
`ifdef DEBUG_ARB_TAG_EN
                    ST_TAG: begin
                        if (!req_sync[active_id]) begin
                            grant <= '0;
                            state <= ST_ARB;
                        end else if (dwell_cnt == TAG_LAST) begin
                            debug_out <= src_word;
                            dwell_cnt <= '0;
                            state     <= ST_GRANT;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                        end
                    end
`endif
                    ST_GRANT: begin
                        if (!req_sync[active_id]) begin
                            grant <= '0;
                            state <= ST_ARB;
                        end else begin
                            debug_out <= src_word;
                            if (dwell_cnt == DWELL_LAST) begin
                                grant     <= '0;
                                dwell_cnt <= '0;
                                state     <= ST_ARB;
                            end else begin
                                dwell_cnt <= dwell_cnt + 1'b1;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_debug_port_arbiter.sv
// ============================================================================
// tb_debug_port_arbiter : directed self-checking bench for debug_port_arbiter.
// Revision              : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_debug_port_arbiter;

    localparam int DWELL = 600;
`ifdef DEBUG_ARB_TAG_EN
    localparam int EXTRA = 120;
`else
    localparam int EXTRA = 0;
`endif
    localparam int SETTLE = EXTRA + 10;

    logic        clk0012p0 = 1'b0;
    logic        user_reset_button;
    logic [3:0]  req;
    logic [63:0] src_data;
    logic        btn_n;
    logic [15:0] debug_out;
    logic [3:0]  grant;
    logic        mode_manual;
    logic [1:0]  active_id;

    int errors = 0;
    int checks = 0;
    logic [15:0] data [4];

    debug_port_arbiter dut (
        .clk0012p0         (clk0012p0),
        .user_reset_button (user_reset_button),
        .req               (req),
        .src_data          (src_data),
        .btn_n             (btn_n),
        .debug_out         (debug_out),
        .grant             (grant),
        .mode_manual       (mode_manual),
        .active_id         (active_id)
    );

    always #5 clk0012p0 = ~clk0012p0;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk0012p0);
    endtask

    task automatic wait_grant(output logic [3:0] g, output int gap);
        gap = 0;
        while (grant == 4'b0000 && gap < 50) begin
            cyc(1);
            gap++;
        end
        g = grant;
    endtask

    task automatic hold_len(input logic [3:0] g, output int len, output logic [15:0] dv);
        len = 0;
        dv  = 16'hxxxx;
        while (grant == g && len < 2000) begin
            if (len == SETTLE) dv = debug_out;
            cyc(1);
            len++;
        end
    endtask

    task automatic test_reset;
        user_reset_button = 1'b1;
        req = 4'b0000;
        btn_n = 1'b1;
        cyc(3);
        checks++; if (debug_out !== 16'h0000) begin errors++; $display("FAIL reset_debug_out got=%h exp=0000", debug_out); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b exp=0000", grant); end
        checks++; if (mode_manual !== 1'b0) begin errors++; $display("FAIL reset_mode got=%b exp=0", mode_manual); end
        checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL reset_active_id got=%0d exp=0", active_id); end
        user_reset_button = 1'b0;
        cyc(2);
    endtask

    task automatic test_single;
        logic [3:0] g; int gap; int len; logic [15:0] dv;
        req = 4'b0001;
        wait_grant(g, gap);
        checks++; if (gap < 3 || gap > 4) begin errors++; $display("FAIL single_latency got=%0d exp=3..4", gap); end
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_grant got=%b exp=0001", g); end
        hold_len(4'b0001, len, dv);
        checks++; if (len != DWELL + EXTRA) begin errors++; $display("FAIL single_dwell got=%0d exp=%0d", len, DWELL + EXTRA); end
        checks++; if (dv !== 16'h1234) begin errors++; $display("FAIL single_data got=%h exp=1234", dv); end
        wait_grant(g, gap);
        checks++; if (gap != 1) begin errors++; $display("FAIL single_regrant_gap got=%0d exp=1", gap); end
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL single_regrant got=%b exp=0001", g); end
    endtask

    task automatic test_round_robin;
        logic [3:0] g; int gap; int len; logic [15:0] dv;
        int order [3];
        order = '{1, 3, 0};
        req = 4'b1011;
        hold_len(4'b0001, len, dv);
        for (int i = 0; i < 3; i++) begin
            wait_grant(g, gap);
            checks++; if (g !== (4'b0001 << order[i])) begin errors++; $display("FAIL rr_order[%0d] got=%b exp=%b", i, g, 4'b0001 << order[i]); end
            checks++; if (gap != 1) begin errors++; $display("FAIL rr_gap[%0d] got=%0d exp=1", i, gap); end
            hold_len(g, len, dv);
            checks++; if (len != DWELL + EXTRA) begin errors++; $display("FAIL rr_dwell[%0d] got=%0d exp=%0d", i, len, DWELL + EXTRA); end
            checks++; if (dv !== data[order[i]]) begin errors++; $display("FAIL rr_data[%0d] got=%h exp=%h", i, dv, data[order[i]]); end
        end
    endtask

    task automatic test_req_drop;
        logic [3:0] g; int gap; int k;
        wait_grant(g, gap);
        checks++; if (g !== 4'b0010) begin errors++; $display("FAIL drop_owner got=%b exp=0010", g); end
        cyc(100);
        req = 4'b1000;
        k = 0;
        while (grant != 4'b0000 && k < 6) begin
            cyc(1);
            k++;
        end
        checks++; if (k > 3) begin errors++; $display("FAIL drop_clear got=%0d cycles exp<=3", k); end
        wait_grant(g, gap);
        checks++; if (g !== 4'b1000) begin errors++; $display("FAIL drop_next got=%b exp=1000", g); end
        checks++; if (active_id !== 2'd3) begin errors++; $display("FAIL drop_id got=%0d exp=3", active_id); end
        cyc(SETTLE);
        checks++; if (debug_out !== 16'hC0DE) begin errors++; $display("FAIL drop_data got=%h exp=c0de", debug_out); end
    endtask

    task automatic test_short_press;
        int k; int bad;
        for (int i = 0; i < 3; i++) begin
            btn_n = 1'b0; cyc(5);
            btn_n = 1'b1; cyc(5);
        end
        cyc(5);
        checks++; if (mode_manual !== 1'b0) begin errors++; $display("FAIL bounce_ignored got=%b exp=0", mode_manual); end
        btn_n = 1'b0; cyc(50);
        btn_n = 1'b1;
        k = 0;
        while (mode_manual != 1'b1 && k < 40) begin cyc(1); k++; end
        checks++; if (mode_manual !== 1'b1) begin errors++; $display("FAIL short_enter_manual got=%b exp=1", mode_manual); end
        checks++; if (active_id !== 2'd3) begin errors++; $display("FAIL short_frozen_id got=%0d exp=3", active_id); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (mode_manual !== 1'b1 || active_id !== 2'd3 || grant !== 4'b1000) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL short_single_press got=%0d bad cycles exp=0", bad); end
        req = 4'b0000;
        btn_n = 1'b0; cyc(40);
        btn_n = 1'b1;
        k = 0;
        while (active_id == 2'd3 && k < 60) begin cyc(1); k++; end
        checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL short_advance got=%0d exp=0", active_id); end
        cyc(5);
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL manual_grant got=%b exp=0001", grant); end
        cyc(SETTLE);
        checks++; if (debug_out !== 16'h1234) begin errors++; $display("FAIL manual_data got=%h exp=1234", debug_out); end
    endtask

    task automatic test_long_press;
        btn_n = 1'b0;
        cyc(1220);
        checks++; if (mode_manual !== 1'b1) begin errors++; $display("FAIL long_early got=%b exp=1", mode_manual); end
        cyc(15);
        checks++; if (mode_manual !== 1'b0) begin errors++; $display("FAIL long_fire got=%b exp=0", mode_manual); end
        cyc(65);
        btn_n = 1'b1;
        cyc(80);
        checks++; if (mode_manual !== 1'b0) begin errors++; $display("FAIL long_release_ignored got=%b exp=0", mode_manual); end
        checks++; if (active_id !== 2'd0) begin errors++; $display("FAIL long_id got=%0d exp=0", active_id); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL long_auto_idle got=%b exp=0000", grant); end
    endtask

    task automatic test_reset_mid_grant;
        logic [3:0] g; int gap;
        req = 4'b0001;
        wait_grant(g, gap);
        cyc(20);
        #2 user_reset_button = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000 || debug_out !== 16'h0000 || mode_manual !== 1'b0 || active_id !== 2'd0) begin
            errors++; $display("FAIL reset_mid got=%b/%h/%b/%0d exp=0000/0000/0/0", grant, debug_out, mode_manual, active_id);
        end
        req = 4'b0011;
        cyc(2);
        user_reset_button = 1'b0;
        wait_grant(g, gap);
        checks++; if (g !== 4'b0001) begin errors++; $display("FAIL reset_rr_first got=%b exp=0001", g); end
    endtask

`ifdef DEBUG_ARB_TAG_EN
    task automatic test_tag;
        logic [3:0] g; int gap; int n;
        user_reset_button = 1'b1; req = 4'b0100; cyc(2);
        user_reset_button = 1'b0;
        wait_grant(g, gap);
        checks++; if (g !== 4'b0100) begin errors++; $display("FAIL tag_grant got=%b exp=0100", g); end
        n = 0;
        while (debug_out == 16'hA502 && n < 300) begin cyc(1); n++; end
        checks++; if (n != 120) begin errors++; $display("FAIL tag_len got=%0d exp=120", n); end
        checks++; if (debug_out !== 16'h2222) begin errors++; $display("FAIL tag_then_data got=%h exp=2222", debug_out); end
        user_reset_button = 1'b1; cyc(2);
        user_reset_button = 1'b0;
        wait_grant(g, gap);
        cyc(30);
        checks++; if (debug_out !== 16'hA502) begin errors++; $display("FAIL tag_mid got=%h exp=a502", debug_out); end
        #2 user_reset_button = 1'b1;
        #1;
        checks++; if (grant !== 4'b0000 || debug_out !== 16'h0000 || mode_manual !== 1'b0 || active_id !== 2'd0) begin
            errors++; $display("FAIL tag_reset got=%b/%h/%b/%0d exp=0000/0000/0/0", grant, debug_out, mode_manual, active_id);
        end
        cyc(2);
        user_reset_button = 1'b0;
    endtask
`endif

    initial begin
        data = '{16'h1234, 16'hBEEF, 16'h2222, 16'hC0DE};
        src_data = {data[3], data[2], data[1], data[0]};
        user_reset_button = 1'b1;
        req = 4'b0000;
        btn_n = 1'b1;
        test_reset();
        test_single();
        test_round_robin();
        test_req_drop();
        test_short_press();
        test_long_press();
        test_reset_mid_grant();
`ifdef DEBUG_ARB_TAG_EN
        test_tag();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
